memchip_banked: RTL and testbench

// - Clocked, parametrised successor of the 64-word memory chip: ROM region plus RAM_BANKS RAM banks behind one port.
// - Adds a req/ready/valid handshake, registered 1-cycle read latency and post-reset RAM clear.
// - Adds an error response for unmapped addresses and ROM writes.
// - Sits between the datapath/controller and storage; default map matches the 64-word chip.

---
 rtl/memchip_pkg.sv | 22 ++
 rtl/mem_bank.sv | 17 +
 rtl/memchip_banked.sv | 97 +++++++++
 tb/tb_memchip_banked.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/memchip_pkg.sv
// memchip_pkg: shared types and address decode for memchip_banked
package memchip_pkg;
   typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;
   typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_NONE} region_t;
   typedef struct packed {
      region_t    region;
      logic [1:0] bank;
   } decode_t;
   // int-wide compares keep the region checks free of address wrap-around
   function automatic decode_t decode(input int a, input int rom_depth, input int ram_banks,
                                      input int bank_depth, input int ram_base, input int bank_stride);
      decode_t d;
      d.region = a < rom_depth ? REG_ROM : REG_NONE;
      d.bank = '0;
      for (int k = 0; k < 4; k++)
         if (k < ram_banks && a >= ram_base + k * bank_stride && a < ram_base + k * bank_stride + bank_depth) begin
            d.region = REG_RAM;
            d.bank = 2'(k);
         end
      return d;
   endfunction
endpackage

// File: rtl/mem_bank.sv
// mem_bank: single-port RAM bank, synchronous write, combinational read
module mem_bank #(
   parameter int DEPTH = 8,
   parameter int W     = 16,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/memchip_banked.sv
// memchip_banked: ROM + banked RAM behind a req/ready/valid port with post-reset RAM clear.
// Optional MEMCHIP_PARITY_EN adds a stored even-parity bit per RAM word and a par_err output.
module memchip_banked
   import memchip_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 6,
   parameter int ROM_DEPTH   = 16,
   parameter int RAM_BANKS   = 2,
   parameter int BANK_DEPTH  = 8,
   parameter int RAM_BASE    = 16,
   parameter int BANK_STRIDE = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] in,
   output logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] out,
   output logic              err
`ifdef MEMCHIP_PARITY_EN
   ,
   output logic              par_err
`endif
);
   localparam int IW = BANK_DEPTH > 1 ? $clog2(BANK_DEPTH) : 1;
`ifdef MEMCHIP_PARITY_EN
   localparam int BW = DATA_W + 1;
`else
   localparam int BW = DATA_W;
`endif
   state_t         state;
   logic [IW-1:0]  idx;
   logic           err_q;
   decode_t        dec;
   logic           accept;
   logic           bad;
   logic           ram_rd;
   logic [BW-1:0]  wword;
   logic [BW-1:0]  rd;
   logic [BW-1:0]  rdata [RAM_BANKS];
   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return ~DATA_W'(a);
   endfunction
   assign dec = decode(int'(addr), ROM_DEPTH, RAM_BANKS, BANK_DEPTH, RAM_BASE, BANK_STRIDE);
   assign accept = state == IDLE && req;
   assign bad = dec.region == REG_NONE || (dec.region == REG_ROM && rw);
   assign ram_rd = dec.region == REG_RAM && !rw;
`ifdef MEMCHIP_PARITY_EN
   assign wword = {^in, in};
`else
   assign wword = in;
`endif
   for (genvar k = 0; k < RAM_BANKS; k++) begin : g_bank
      logic we;
      assign we = !rst && (state == INIT || (accept && rw && dec.region == REG_RAM && dec.bank == 2'(k)));
      mem_bank #(.DEPTH(BANK_DEPTH), .W(BW), .AW(IW)) u_bank (
         .clk   (clk),
         .we    (we),
         .addr  (state == INIT ? idx : addr[IW-1:0]),
         .wdata (state == INIT ? '0 : wword),
         .rdata (rdata[k])
      );
   end
   always_comb begin
      rd = '0;
      for (int k = 0; k < RAM_BANKS; k++)
         if (dec.bank == 2'(k)) rd = rdata[k];
   end
   // a reset arriving during RESP suppresses the pending response
   assign ready = state == IDLE;
   assign valid = state == RESP && !rst;
   assign err = err_q && !rst;
   always_ff @(posedge clk)
      if (rst) begin
         state <= INIT;
         idx <= '0;
         err_q <= 1'b0;
         out <= '0;
`ifdef MEMCHIP_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         idx <= state == INIT ? idx + IW'(1) : idx;
         state <= state == INIT ? (idx == IW'(BANK_DEPTH - 1) ? IDLE : INIT) :
                  state == RESP ? IDLE : accept ? RESP : state;
         err_q <= accept && bad;
         if (accept && !rw && dec.region == REG_ROM) out <= rom_word(addr);
         else if (accept && ram_rd) out <= rd[DATA_W-1:0];
`ifdef MEMCHIP_PARITY_EN
         par_err <= accept ? ram_rd && ^rd : par_err;
`endif
      end
endmodule

// File: tb/tb_memchip_banked.sv
// tb_memchip_banked: directed scoreboard bench for memchip_banked (MEMCHIP_PARITY_EN adds parity steps)
module tb_memchip_banked;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        rw = 1'b0;
   logic [5:0]  addr = '0;
   logic [15:0] in = '0;
   logic        ready;
   logic        valid;
   logic [15:0] out;
   logic        err;
`ifdef MEMCHIP_PARITY_EN
   logic        par_err;
`endif
   typedef struct {
      logic        err;
      logic [15:0] out;
   } exp_t;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   memchip_banked dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .rw    (rw),
      .addr  (addr),
      .in    (in),
      .ready (ready),
      .valid (valid),
      .out   (out),
      .err   (err)
`ifdef MEMCHIP_PARITY_EN
      ,
      .par_err (par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reset pulse, then ready must stay low for exactly 8 cycles with no valid
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("init_ready", 32'(ready), 0);
         chk("init_valid", 32'(valid), 0);
         @(negedge clk);
      end
      chk("ready_after_init", 32'(ready), 1);
   endtask

   task automatic access(input string tag, input logic w, input logic [5:0] a, input logic [15:0] d,
                         input logic e_err, input logic [15:0] e_out);
      exp_t e;
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(ready), 1);
      sb.push_back('{e_err, e_out});
      req = 1'b1;
      rw = w;
      addr = a;
      in = d;
      @(negedge clk);
      req = 1'b0;
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(valid), 1);
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_out"}, 32'(out), 32'(e.out));
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(valid), 0);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      chk("reset_out", 32'(out), 0);
      access("rom0", 0, 6'd0, 16'h0, 0, 16'hFFFF);
      access("rom5", 0, 6'd5, 16'h0, 0, 16'hFFFA);
      access("rom15", 0, 6'd15, 16'h0, 0, 16'hFFF0);
      access("wr17", 1, 6'd17, 16'h1234, 0, 16'hFFF0);
      access("rd17", 0, 6'd17, 16'h0, 0, 16'h1234);
      access("rd16", 0, 6'd16, 16'h0, 0, 16'h0000);
      access("rd33", 0, 6'd33, 16'h0, 0, 16'h0000);
      access("wr39", 1, 6'd39, 16'hBEEF, 0, 16'h0000);
      access("rd39", 0, 6'd39, 16'h0, 0, 16'hBEEF);
      access("rd17b", 0, 6'd17, 16'h0, 0, 16'h1234);
      access("rd23", 0, 6'd23, 16'h0, 0, 16'h0000);
      access("romwr3", 1, 6'd3, 16'h5555, 1, 16'h0000);
      access("rd3", 0, 6'd3, 16'h0, 0, 16'hFFFC);
      access("rd24", 0, 6'd24, 16'h0, 1, 16'hFFFC);
      access("rd63", 0, 6'd63, 16'h0, 1, 16'hFFFC);
      access("rd40", 0, 6'd40, 16'h0, 1, 16'hFFFC);
      access("wr24", 1, 6'd24, 16'h7777, 1, 16'hFFFC);
      access("rd32", 0, 6'd32, 16'h0, 0, 16'h0000);
      // req held high: accepted only every second cycle
      req = 1'b1;
      rw = 1'b0;
      addr = 6'd5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("held_valid", 32'(valid), 32'(i % 2 == 0));
         chk("held_ready", 32'(ready), 32'(i % 2 == 1));
      end
      req = 1'b0;
      chk("held_out", 32'(out), 16'hFFFA);
      // write accepted, then reset lands during RESP
      req = 1'b1;
      rw = 1'b1;
      addr = 6'd18;
      in = 16'hDEAD;
      @(negedge clk);
      req = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_resp_valid", 32'(valid), 0);
      @(negedge clk);
      chk("rst_valid", 32'(valid), 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("reinit_valid", 32'(valid), 0);
         chk("reinit_ready", 32'(ready), 0);
         @(negedge clk);
      end
      access("rd18", 0, 6'd18, 16'h0, 0, 16'h0000);
      access("rd39c", 0, 6'd39, 16'h0, 0, 16'h0000);
`ifdef MEMCHIP_PARITY_EN
      access("wr20", 1, 6'd20, 16'hA5A5, 0, 16'h0000);
      dut.g_bank[0].u_bank.mem[4][0] = ~dut.g_bank[0].u_bank.mem[4][0];
      access("rd20", 0, 6'd20, 16'h0, 0, 16'hA5A4);
      chk("par_err20", 32'(par_err), 1);
      access("rd21", 0, 6'd21, 16'h0, 0, 16'h0000);
      chk("par_err21", 32'(par_err), 0);
      access("wr20b", 1, 6'd20, 16'h0F0F, 0, 16'h0000);
      access("rom1", 0, 6'd1, 16'h0, 0, 16'hFFFE);
      chk("par_err_rom", 32'(par_err), 0);
`endif
      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
